// File: rtl/bus_mux_arb.sv
// Priority bus driver: highest enabled source wins, idle bus holds the last driven value,
// multi-driver conflicts flagged and counted. Define BUS_OUT_REG_EN to register the bus outputs.
module bus_mux_arb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 24,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned SEL_W = $clog2(NSRC)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_out,
    input  logic                  conflict_clr,
    output logic [WIDTH-1:0]      bus_out,
    output logic [SEL_W-1:0]      bus_src,
    output logic                  bus_drv,
    output logic                  conflict,
    output logic                  conflict_sticky,
    output logic [CNT_W-1:0]      conflict_cnt
);

    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] sel_data;
    logic             drv;
    logic             conflict_c;
    logic [WIDTH-1:0] hold_q;
    logic [SEL_W-1:0] hold_src_q;
    logic [WIDTH-1:0] bus_c;
    logic [SEL_W-1:0] src_c;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;

    // Ascending scan so the highest asserted index overwrites lower ones.
    always_comb begin
        sel      = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (src_out[i]) begin
                sel      = SEL_W'(i);
                sel_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign drv = |src_out;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign conflict_c = |(src_out & (src_out - NSRC'(1)));

    assign bus_c = drv ? sel_data : hold_q;
    assign src_c = drv ? sel : hold_src_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            hold_q     <= '0;
            hold_src_q <= '0;
        end else if (drv) begin
            hold_q     <= sel_data;
            hold_src_q <= sel;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (conflict_clr) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (conflict_c) begin
            sticky_q <= 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign conflict_sticky = sticky_q;
    assign conflict_cnt    = cnt_q;

`ifdef BUS_OUT_REG_EN
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            bus_out  <= '0;
            bus_src  <= '0;
            bus_drv  <= 1'b0;
            conflict <= 1'b0;
        end else begin
            bus_out  <= bus_c;
            bus_src  <= src_c;
            bus_drv  <= drv;
            conflict <= conflict_c;
        end
    end
`else
    assign bus_out  = bus_c;
    assign bus_src  = src_c;
    assign bus_drv  = drv;
    assign conflict = conflict_c;
`endif

endmodule
